main_memory_ctrl: RTL and testbench

Word-addressed main-memory responder that sits directly downstream of the cache controller's memory port. It accepts one read or write request at a time, models a fixed, parameterised access latency, and completes each request with a single-cycle `mem_ack` pulse. Read data comes from an internal backing store. The block acts as the refill and writeback target for cache allocate, writeback and flush traffic.

---
 rtl/mem_pkg.sv | 21 ++
 rtl/mem_storage.sv | 26 ++
 rtl/main_memory_ctrl.sv | 156 +++++++++++++++
 tb/tb_main_memory_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and default parameters for the main-memory responder.
package mem_pkg;

    typedef enum logic [1:0] {
        M_IDLE,
        M_WAIT,
        M_ACK
    } mem_state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } mem_op_t;

    localparam int unsigned DEF_ADDR_WIDTH    = 32;
    localparam int unsigned DEF_DATA_WIDTH    = 32;
    localparam int unsigned DEF_MEM_DEPTH     = 1024;
    localparam int unsigned DEF_READ_LATENCY  = 4;
    localparam int unsigned DEF_WRITE_LATENCY = 4;

endpackage

// File: rtl/mem_storage.sv
// Single-port backing store: synchronous write, combinational read, no reset.
module mem_storage #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MEM_DEPTH  = 1024,
    localparam int unsigned IDX_W     = $clog2(MEM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [IDX_W-1:0]      addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_comb begin
        rdata = mem[addr];
    end

endmodule

// File: rtl/main_memory_ctrl.sv
// Fixed-latency word-addressed memory responder: one request in flight,
// single-cycle ack, out-of-range accesses flagged with mem_error.
module main_memory_ctrl
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int unsigned MEM_DEPTH     = DEF_MEM_DEPTH,
    parameter int unsigned READ_LATENCY  = DEF_READ_LATENCY,
    parameter int unsigned WRITE_LATENCY = DEF_WRITE_LATENCY
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_read_enable,
    input  logic                  mem_write_enable,
    input  logic [ADDR_WIDTH-1:0] mem_address,
    input  logic [DATA_WIDTH-1:0] mem_write_data,
    output logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  mem_ack,
    output logic                  mem_busy,
    output logic                  mem_error
);

    localparam int unsigned IDX_W   = $clog2(MEM_DEPTH);
    localparam int unsigned MAX_LAT = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT) + 1;
    localparam int unsigned WA_W    = ADDR_WIDTH - 2;

    mem_state_t            state_q, state_d;
    mem_op_t               op_q, op_d;
    logic [WA_W-1:0]       addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [CNT_W-1:0]      lat_cnt_q, lat_cnt_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  ack_q, ack_d;
    logic                  busy_q, busy_d;
    logic                  err_q, err_d;

    mem_op_t               req_op, sel_op;
    logic [WA_W-1:0]       sel_addr;
    logic [IDX_W-1:0]      sel_idx;
    logic                  sel_oor;
    logic [CNT_W-1:0]      load_cnt;
    logic                  enter_ack;
    logic                  store_we;
    logic [DATA_WIDTH-1:0] store_rdata;
    logic                  addr_lsb_unused;

    // In M_IDLE the live inputs are the request; elsewhere the captured copy is.
    always_comb begin
        addr_lsb_unused = ^mem_address[1:0];
        req_op   = mem_write_enable ? OP_WRITE : OP_READ;
        sel_op   = (state_q == M_IDLE) ? req_op : op_q;
        sel_addr = (state_q == M_IDLE) ? mem_address[ADDR_WIDTH-1:2] : addr_q;
        sel_idx  = sel_addr[IDX_W-1:0];
        sel_oor  = |sel_addr[WA_W-1:IDX_W];
        store_we = (state_q == M_ACK) && (op_q == OP_WRITE) && !sel_oor;
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        lat_cnt_d = lat_cnt_q;
        rdata_d   = rdata_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        load_cnt  = '0;
        enter_ack = 1'b0;

        unique case (state_q)
            M_IDLE: begin
                if (mem_read_enable || mem_write_enable) begin
                    op_d     = req_op;
                    addr_d   = mem_address[ADDR_WIDTH-1:2];
                    wdata_d  = mem_write_data;
                    load_cnt = (req_op == OP_WRITE) ? CNT_W'(WRITE_LATENCY - 1)
                                                    : CNT_W'(READ_LATENCY - 1);
                    lat_cnt_d = load_cnt;
                    if (load_cnt == '0) begin
                        enter_ack = 1'b1;
                    end else begin
                        state_d = M_WAIT;
                    end
                end
            end
            M_WAIT: begin
                lat_cnt_d = lat_cnt_q - CNT_W'(1);
                if (lat_cnt_q == CNT_W'(1)) begin
                    enter_ack = 1'b1;
                end
            end
            M_ACK: begin
                state_d = M_IDLE;
            end
            default: begin
                state_d = M_IDLE;
            end
        endcase

        if (enter_ack) begin
            state_d = M_ACK;
            ack_d   = 1'b1;
            err_d   = sel_oor;
            if (sel_op == OP_READ) begin
                rdata_d = sel_oor ? '0 : store_rdata;
            end
        end

        busy_d = (state_d != M_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= M_IDLE;
            op_q      <= OP_READ;
            addr_q    <= '0;
            wdata_q   <= '0;
            lat_cnt_q <= '0;
            rdata_q   <= '0;
            ack_q     <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            lat_cnt_q <= lat_cnt_d;
            rdata_q   <= rdata_d;
            ack_q     <= ack_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end

    mem_storage #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH)
    ) u_storage (
        .clk   (clk),
        .we    (store_we),
        .addr  (sel_idx),
        .wdata (wdata_q),
        .rdata (store_rdata)
    );

    always_comb begin
        mem_read_data = rdata_q;
        mem_ack       = ack_q;
        mem_busy      = busy_q;
        mem_error     = err_q;
    end

endmodule

// File: tb/tb_main_memory_ctrl.sv
// Directed bench for main_memory_ctrl with a cycle-count reference model.
module tb_main_memory_ctrl;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        re = 1'b0;
    logic        we = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] mem_read_data;
    logic        mem_ack, mem_busy, mem_error;

    int vectors = 0;
    int miscompares = 0;

    main_memory_ctrl #(
        .ADDR_WIDTH    (32),
        .DATA_WIDTH    (32),
        .MEM_DEPTH     (1024),
        .READ_LATENCY  (LAT),
        .WRITE_LATENCY (LAT)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .mem_read_enable  (re),
        .mem_write_enable (we),
        .mem_address      (addr),
        .mem_write_data   (wdata),
        .mem_read_data    (mem_read_data),
        .mem_ack          (mem_ack),
        .mem_busy         (mem_busy),
        .mem_error        (mem_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit out_of_range(input logic [31:0] a);
        return |a[31:12];
    endfunction

    // Reference model: a request accepted at the end of cycle c acks in cycle c+LAT.
    logic [31:0] mmem [1024];
    bit          pend = 1'b0;
    int          cyc = 0;
    int          ack_at = 0;
    bit          m_write = 1'b0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_data = '0;
    bit          exp_ack = 1'b0;
    bit          exp_busy = 1'b0;
    bit          exp_err = 1'b0;
    logic [31:0] exp_rd = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend = 1'b0;
            exp_ack = 1'b0;
            exp_busy = 1'b0;
            exp_err = 1'b0;
            exp_rd = '0;
        end else begin
            if (pend && cyc == ack_at) begin
                if (m_write && !out_of_range(m_addr)) mmem[m_addr[11:2]] = m_data;
                pend = 1'b0;
            end else if (!pend && (re || we)) begin
                pend = 1'b1;
                ack_at = cyc + LAT;
                m_write = we;
                m_addr = addr;
                m_data = wdata;
            end
            cyc++;
            exp_ack = pend && (cyc == ack_at);
            exp_busy = pend;
            exp_err = exp_ack && out_of_range(m_addr);
            if (exp_ack && !m_write) exp_rd = out_of_range(m_addr) ? '0 : mmem[m_addr[11:2]];
        end
    end

    always @(negedge clk) begin
        chk("ack", {31'b0, mem_ack}, {31'b0, exp_ack});
        chk("busy", {31'b0, mem_busy}, {31'b0, exp_busy});
        chk("error", {31'b0, mem_error}, {31'b0, exp_err});
        chk("rdata", mem_read_data, exp_rd);
    end

    task automatic req(input bit r, input bit w, input logic [31:0] a, input logic [31:0] d,
                       output int lat, output logic [31:0] rd, output logic err);
        @(negedge clk);
        re = r; we = w; addr = a; wdata = d;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!mem_ack && lat < 20);
        chk("ack_seen", {31'b0, mem_ack}, 32'd1);
        rd = mem_read_data;
        err = mem_error;
        re = 1'b0; we = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int          lat;
        logic [31:0] rd;
        logic        err;
        int          n;
        int          acks[$];

        repeat (3) @(negedge clk);
        chk("rst_rd", mem_read_data, 32'h0);
        rst_n = 1'b1;

        req(0, 1, 32'h0000_0000, 32'hA5A5_0000, lat, rd, err);
        req(0, 1, 32'h0000_0014, 32'h1414_1414, lat, rd, err);
        req(0, 1, 32'h0000_0030, 32'h3030_3030, lat, rd, err);

        req(0, 1, 32'h0000_0040, 32'hDEAD_BEEF, lat, rd, err);
        chk("wr_lat", lat, 32'd4);
        req(1, 0, 32'h0000_0040, 32'h0, lat, rd, err);
        chk("rd_lat", lat, 32'd4);
        chk("rd_data", rd, 32'hDEAD_BEEF);
        chk("rd_err", {31'b0, err}, 32'd0);

        // Change address and data while the write is waiting.
        @(negedge clk);
        we = 1'b1; addr = 32'h10; wdata = 32'h1111_0010;
        @(negedge clk);
        addr = 32'h14; wdata = 32'hBAD0_BAD0;
        n = 1;
        while (!mem_ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("stab_lat", n, 32'd4);
        we = 1'b0;
        req(1, 0, 32'h10, 32'h0, lat, rd, err);
        chk("stab_10", rd, 32'h1111_0010);
        req(1, 0, 32'h14, 32'h0, lat, rd, err);
        chk("stab_14", rd, 32'h1414_1414);

        req(1, 0, 32'h0000_1000, 32'h0, lat, rd, err);
        chk("oor_rd_lat", lat, 32'd4);
        chk("oor_rd_data", rd, 32'h0);
        chk("oor_rd_err", {31'b0, err}, 32'd1);
        req(0, 1, 32'h0000_1000, 32'hFFFF_FFFF, lat, rd, err);
        chk("oor_wr_err", {31'b0, err}, 32'd1);
        req(1, 0, 32'h0000_0000, 32'h0, lat, rd, err);
        chk("oor_alias", rd, 32'hA5A5_0000);

        req(1, 1, 32'h0000_0020, 32'h2020_CAFE, lat, rd, err);
        chk("rw_err", {31'b0, err}, 32'd0);
        chk("rw_hold", rd, 32'hA5A5_0000);
        req(1, 0, 32'h0000_0020, 32'h0, lat, rd, err);
        chk("rw_data", rd, 32'h2020_CAFE);

        // Held read: acks expected at cycles 4, 9, 14.
        @(negedge clk);
        re = 1'b1; addr = 32'h40;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (mem_ack) acks.push_back(i);
        end
        re = 1'b0;
        chk("b2b_count", acks.size(), 32'd3);
        if (acks.size() == 3) begin
            chk("b2b_first", acks[0], 32'd4);
            chk("b2b_gap1", acks[1] - acks[0], 32'd5);
            chk("b2b_gap2", acks[2] - acks[1], 32'd5);
        end
        repeat (8) @(negedge clk);

        // Abort a write to 0x30 with reset during the wait.
        @(negedge clk);
        we = 1'b1; addr = 32'h30; wdata = 32'h0000_1234;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b0;
        we = 1'b0;
        @(negedge clk);
        chk("rst_ack", {31'b0, mem_ack}, 32'd0);
        chk("rst_busy", {31'b0, mem_busy}, 32'd0);
        chk("rst_rd_mid", mem_read_data, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        req(1, 0, 32'h30, 32'h0, lat, rd, err);
        chk("rst_keep", rd, 32'h3030_3030);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
